// File: rtl/sram_arbiter.sv
// Three-port SRAM arbiter: video reads, CPU reads/writes and DMA writes share one
// asynchronous SRAM through a registered 3-cycle read / 4-cycle write sequence.
module sram_arbiter #(
    parameter logic [4:0] BANK_NORMAL = 5'd5,
    parameter logic [4:0] BANK_SHADOW = 5'd7,
    parameter logic [2:0] DMA_MAX     = 3'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    input  logic        vid_page,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    input  logic        dma_req,
    input  logic [18:0] dma_addr,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_data_o,
    output logic        sram_data_oe,
    input  logic [7:0]  sram_data_i,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_WR1  = 3'd3,
        S_WR2  = 3'd4,
        S_WR3  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_NONE = 2'd0,
        P_VID  = 2'd1,
        P_CPU  = 2'd2,
        P_DMA  = 2'd3
    } port_t;

    state_t      state_q, state_d;
    port_t       port_q, port_d;
    port_t       grant_s;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        oe_q, oe_d;
    logic        we_n_q, we_n_d;
    logic        vid_ack_q, vid_ack_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [2:0]  starve_q, starve_d;

    logic        vid_req_m_s;
    logic        cpu_req_m_s;
    logic        dma_req_m_s;
    logic        dma_over_s;
    logic        cpu_hold_s;
    logic        done_s;
    logic [4:0]  bank_s;

    assign vid_req_m_s = vid_req & ~vid_ack_q;
    assign cpu_req_m_s = cpu_req & ~cpu_ack_q;
    assign dma_req_m_s = dma_req & ~dma_ack_q;
    assign dma_over_s  = dma_req_m_s & (starve_q == DMA_MAX);
    // A CPU still holding req in its own ack cycle keeps its turn, so DMA does not
    // slip in through the mask and bypass the starvation counter.
    assign cpu_hold_s  = cpu_ack_q & cpu_req;
    assign done_s      = (state_q == S_RD2) || (state_q == S_WR3);
    assign bank_s      = vid_page ? BANK_SHADOW : BANK_NORMAL;

    // Grant decision, taken only while idle
    always_comb begin
        grant_s = P_NONE;
        if (state_q == S_IDLE) begin
            if (vid_req_m_s) begin
                grant_s = P_VID;
            end else if (dma_over_s) begin
                grant_s = P_DMA;
            end else if (cpu_req_m_s) begin
                grant_s = P_CPU;
            end else if (dma_req_m_s && !cpu_hold_s) begin
                grant_s = P_DMA;
            end else begin
                grant_s = P_NONE;
            end
        end else begin
            grant_s = P_NONE;
        end
    end

    // Access sequencer next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                case (grant_s)
                    P_VID:   state_d = S_RD1;
                    P_CPU:   state_d = cpu_we ? S_WR1 : S_RD1;
                    P_DMA:   state_d = S_WR1;
                    default: state_d = S_IDLE;
                endcase
            end
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_IDLE;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_WR3;
            S_WR3:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath, strobes, acks, read capture and starvation counter next values
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        vid_data_d = vid_data_q;
        cpu_dout_d = cpu_dout_q;
        starve_d   = starve_q;

        case (grant_s)
            P_VID: begin
                addr_d = {bank_s, vid_addr};
                port_d = P_VID;
            end
            P_CPU: begin
                addr_d  = cpu_addr;
                wdata_d = cpu_din;
                port_d  = P_CPU;
            end
            P_DMA: begin
                addr_d  = dma_addr;
                wdata_d = dma_din;
                port_d  = P_DMA;
            end
            default: port_d = port_q;
        endcase

        oe_d      = (state_d == S_WR1) || (state_d == S_WR2) || (state_d == S_WR3);
        we_n_d    = (state_d != S_WR2);
        vid_ack_d = done_s && (port_q == P_VID);
        cpu_ack_d = done_s && (port_q == P_CPU);
        dma_ack_d = done_s && (port_q == P_DMA);

        if ((state_q == S_RD2) && (port_q == P_VID)) begin
            vid_data_d = sram_data_i;
        end else if ((state_q == S_RD2) && (port_q == P_CPU)) begin
            cpu_dout_d = sram_data_i;
        end else begin
            vid_data_d = vid_data_q;
            cpu_dout_d = cpu_dout_q;
        end

        if (!dma_req) begin
            starve_d = 3'd0;
        end else if (grant_s == P_DMA) begin
            starve_d = 3'd0;
        end else if ((grant_s == P_CPU) && (starve_q < DMA_MAX)) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State and output registers; reset drops the write strobe and bus drive at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            port_q     <= P_NONE;
            addr_q     <= 19'd0;
            wdata_q    <= 8'd0;
            oe_q       <= 1'b0;
            we_n_q     <= 1'b1;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            vid_data_q <= 8'd0;
            cpu_dout_q <= 8'd0;
            starve_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            oe_q       <= oe_d;
            we_n_q     <= we_n_d;
            vid_ack_q  <= vid_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
            vid_data_q <= vid_data_d;
            cpu_dout_q <= cpu_dout_d;
            starve_q   <= starve_d;
        end
    end

    assign sram_addr    = addr_q;
    assign sram_data_o  = wdata_q;
    assign sram_data_oe = oe_q;
    assign sram_we_n    = we_n_q;
    assign vid_ack      = vid_ack_q;
    assign cpu_ack      = cpu_ack_q;
    assign dma_ack      = dma_ack_q;
    assign vid_data     = vid_data_q;
    assign cpu_dout     = cpu_dout_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM model;
// inputs change and outputs are sampled on the falling clock edge.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic        vid_page;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        dma_req;
    logic [18:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_ack;
    logic [18:0] sram_addr;
    logic [7:0]  sram_data_o;
    logic        sram_data_oe;
    logic [7:0]  sram_data_i;
    logic        sram_we_n;

    logic [7:0]  mem [0:524287];
    int          n_tests = 0;
    int          n_fail = 0;
    int          multi_ack = 0;

    sram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_page     (vid_page),
        .vid_ack      (vid_ack),
        .vid_data     (vid_data),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_ack      (cpu_ack),
        .cpu_dout     (cpu_dout),
        .dma_req      (dma_req),
        .dma_addr     (dma_addr),
        .dma_din      (dma_din),
        .dma_ack      (dma_ack),
        .sram_addr    (sram_addr),
        .sram_data_o  (sram_data_o),
        .sram_data_oe (sram_data_oe),
        .sram_data_i  (sram_data_i),
        .sram_we_n    (sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: a write lands when the strobe falls, reads are combinational
    assign sram_data_i = mem[sram_addr];
    always @(negedge sram_we_n) mem[sram_addr] <= sram_data_o;

    always @(negedge clk) begin
        if ($countones({vid_ack, cpu_ack, dma_ack}) > 1) multi_ack = multi_ack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] order [6];
        logic [1:0] exp_order [6];
        int         nacks;

        vid_req = 1'b0; vid_addr = 14'd0; vid_page = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 19'd0; cpu_din = 8'd0;
        dma_req = 1'b0; dma_addr = 19'd0; dma_din = 8'd0;
        mem[19'h14010] = 8'hA5;
        mem[19'h1FFFF] = 8'h5A;
        mem[19'h00100] = 8'h77;
        mem[19'h20000] = 8'h11;
        mem[19'h20001] = 8'h22;
        mem[19'h40000] = 8'h00;
        for (int i = 0; i < 6; i++) order[i] = 2'd0;
        exp_order[0] = 2'd1; exp_order[1] = 2'd1; exp_order[2] = 2'd1;
        exp_order[3] = 2'd1; exp_order[4] = 2'd2; exp_order[5] = 2'd1;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_data_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_wdata", 32'(sram_data_o), 32'd0);
        chk("rst_acks", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst_starve", 32'(dut.starve_q), 32'd0);
        rst_n = 1'b1;
        tick;

        // Video read from the normal bank
        vid_req = 1'b1; vid_page = 1'b0; vid_addr = 14'h0010;
        tick;
        chk("vid_addr_T1", 32'(sram_addr), 32'h14010);
        chk("vid_ack_T1", 32'(vid_ack), 32'd0);
        tick;
        chk("vid_ack_T2", 32'(vid_ack), 32'd0);
        tick;
        chk("vid_ack_T3", 32'(vid_ack), 32'd1);
        chk("vid_data_T3", 32'(vid_data), 32'hA5);
        vid_req = 1'b0;
        tick;
        chk("vid_ack_T4", 32'(vid_ack), 32'd0);

        // Video read from the top of the shadow bank
        vid_req = 1'b1; vid_page = 1'b1; vid_addr = 14'h3FFF;
        tick;
        chk("shadow_addr", 32'(sram_addr), 32'h1FFFF);
        tick;
        tick;
        chk("shadow_ack", 32'(vid_ack), 32'd1);
        chk("shadow_data", 32'(vid_data), 32'h5A);
        vid_req = 1'b0;
        tick;

        // CPU write to the last address, inputs disturbed after the grant
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h7FFFF; cpu_din = 8'h3C;
        tick;
        chk("wr_T1_oe", 32'(sram_data_oe), 32'd1);
        chk("wr_T1_we_n", 32'(sram_we_n), 32'd1);
        chk("wr_T1_addr", 32'(sram_addr), 32'h7FFFF);
        chk("wr_T1_data", 32'(sram_data_o), 32'h3C);
        cpu_din = 8'hFF; cpu_addr = 19'd0;
        tick;
        chk("wr_T2_we_n", 32'(sram_we_n), 32'd0);
        chk("wr_T2_oe", 32'(sram_data_oe), 32'd1);
        chk("wr_T2_data", 32'(sram_data_o), 32'h3C);
        tick;
        chk("wr_T3_we_n", 32'(sram_we_n), 32'd1);
        chk("wr_T3_oe", 32'(sram_data_oe), 32'd1);
        chk("wr_T3_ack", 32'(cpu_ack), 32'd0);
        tick;
        chk("wr_T4_ack", 32'(cpu_ack), 32'd1);
        chk("wr_T4_oe", 32'(sram_data_oe), 32'd0);
        chk("wr_mem", 32'(mem[19'h7FFFF]), 32'h3C);
        chk("vid_data_kept", 32'(vid_data), 32'h5A);
        cpu_req = 1'b0;
        tick;

        // CPU read back of the same address
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h7FFFF;
        tick;
        chk("rd_T1_addr", 32'(sram_addr), 32'h7FFFF);
        cpu_addr = 19'h00100;
        tick;
        chk("rd_T2_addr", 32'(sram_addr), 32'h7FFFF);
        tick;
        chk("rd_ack", 32'(cpu_ack), 32'd1);
        chk("rd_data", 32'(cpu_dout), 32'h3C);
        cpu_req = 1'b0;
        tick;

        // Simultaneous video and CPU requests
        vid_req = 1'b1; vid_page = 1'b0; vid_addr = 14'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00100;
        tick;
        chk("both_T1_addr", 32'(sram_addr), 32'h14010);
        tick;
        tick;
        chk("both_T3_vid_ack", 32'(vid_ack), 32'd1);
        chk("both_T3_cpu_ack", 32'(cpu_ack), 32'd0);
        vid_req = 1'b0;
        tick;
        chk("both_T4_addr", 32'(sram_addr), 32'h00100);
        tick;
        tick;
        chk("both_T6_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("both_T6_cpu_dout", 32'(cpu_dout), 32'h77);
        chk("both_T6_vid_ack", 32'(vid_ack), 32'd0);
        cpu_req = 1'b0;
        tick;

        // CPU and DMA held together: starvation counter hands DMA every fifth slot
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00100;
        dma_req = 1'b1; dma_addr = 19'h40000; dma_din = 8'h99;
        nacks = 0;
        for (int c = 0; c < 80 && nacks < 6; c++) begin
            tick;
            if (cpu_ack) begin
                order[nacks] = 2'd1;
                if (nacks == 3) chk("starve_sat", 32'(dut.starve_q), 32'd4);
                nacks = nacks + 1;
            end else if (dma_ack) begin
                order[nacks] = 2'd2;
                chk("starve_clr", 32'(dut.starve_q), 32'd0);
                nacks = nacks + 1;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("order_count", 32'(nacks), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
        tick;
        tick;
        chk("dma_mem", 32'(mem[19'h40000]), 32'h99);

        // Reset during the write strobe
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h20000; cpu_din = 8'hEE;
        tick;
        tick;
        chk("abort_pre_we_n", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_data_oe), 32'd0);
        @(negedge clk);
        chk("abort_ack_a", 32'(cpu_ack), 32'd0);
        chk("abort_vid_data", 32'(vid_data), 32'd0);
        tick;
        chk("abort_ack_b", 32'(cpu_ack), 32'd0);

        // First grant straight after reset release
        rst_n = 1'b1;
        vid_req = 1'b1; vid_page = 1'b0; vid_addr = 14'h0010;
        tick;
        chk("post_rst_addr", 32'(sram_addr), 32'h14010);
        chk("post_rst_cpu_ack", 32'(cpu_ack), 32'd0);
        tick;
        chk("post_rst_cpu_ack2", 32'(cpu_ack), 32'd0);
        tick;
        chk("post_rst_vid_ack", 32'(vid_ack), 32'd1);
        chk("post_rst_vid_data", 32'(vid_data), 32'hA5);
        vid_req = 1'b0;
        tick;
        chk("abort_neighbor", 32'(mem[19'h20001]), 32'h22);
        chk("abort_other", 32'(mem[19'h7FFFF]), 32'h3C);
        chk("one_ack", 32'(multi_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
